bcd_frame_sequencer: RTL and testbench
======================================

BCD_FRAME_SEQUENCER -- requirements
Module: bcd_frame_sequencer

Interface
REQ-001 SHALL have parameter DIGITS_PER_FRAME, default 10, BCD digits per frame.
REQ-002 SHALL have parameter NUM_FRAMES, default 30, frames per run (300 digits).
REQ-003 SHALL have port clk, input, 1, the only clock; one clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins a run when sampled high in IDLE.
REQ-006 SHALL have port abort, input, 1, terminates the run in any state.
REQ-007 SHALL have port in_valid, input, 1, upstream digit valid.
REQ-008 SHALL have port in_digit, input, 4, upstream BCD digit.
REQ-009 SHALL have port in_ready, output, 1, sequencer can accept a digit.
REQ-010 SHALL have port bcd_digits, output, 4*DIGITS_PER_FRAME, assembled frame to the BCD datapath.
REQ-011 SHALL have port frame_valid, output, 1, bcd_digits holds a complete frame.
REQ-012 SHALL have port frame_ready, input, 1, datapath consumes the frame.
REQ-013 SHALL have port frame_idx, output, 5, index of current frame, 0..NUM_FRAMES-1.
REQ-014 SHALL have port bad_count, output, 9, digits >9 seen this run.
REQ-015 SHALL have port busy, output, 1, high in FILL or ISSUE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at normal run completion.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, ISSUE, DONE.
REQ-018 IDLE: in_ready=0, frame_valid=0; start=1 -> FILL; clears digit_idx, frame_idx, bad_count and bcd_digits.
REQ-019 FILL: in_ready=1; a digit is accepted when in_valid and in_ready are both high.
REQ-020 An accepted digit SHALL be written to slot digit_idx, bits [4*k+3:4*k]; slot 0 is the LSBs.
REQ-021 An accepted digit >9 SHALL be stored as 0 and SHALL increment bad_count, saturating at 511.
REQ-022 Acceptance of slot DIGITS_PER_FRAME-1 SHALL move to ISSUE on the next cycle and reset digit_idx to 0.
REQ-023 ISSUE: frame_valid=1, in_ready=0; bcd_digits and frame_idx SHALL hold stable until frame_ready.
REQ-024 ISSUE with frame_ready=1: if frame_idx==NUM_FRAMES-1 -> DONE; otherwise frame_idx+1 -> FILL.
REQ-025 DONE: done=1 for exactly one cycle -> IDLE; frame_idx and bad_count SHALL hold until the next start.
REQ-026 frame_valid SHALL rise the cycle after the last digit of a frame is accepted (latency 1); minimum 11 cycles per frame.
REQ-027 start SHALL be ignored outside IDLE; start and abort high together in IDLE -> stay IDLE.
REQ-028 abort SHALL force IDLE on the next cycle from any state, with no done pulse; bad_count holds; a partial frame is discarded.
REQ-029 abort SHALL take priority over frame_ready and digit acceptance in the same cycle.
REQ-030 busy SHALL equal (state==FILL or state==ISSUE).

Reset
REQ-031 reset SHALL force IDLE, in_ready=0, frame_valid=0, done=0, busy=0, frame_idx=0, bad_count=0, bcd_digits=0.
REQ-032 reset SHALL override start, abort and all handshakes, including mid-run.

Structure
REQ-033 Shared package bcd_pkg SHALL hold BCD_MAX (9), default DIGITS_PER_FRAME/NUM_FRAMES, and the state enum.
REQ-034 Combinational sub-module bcd_digit_check SHALL map a 4-bit digit to sanitized digit plus an invalid flag.

Verification
REQ-035 start, 300 digits value i%10 with in_valid always high, frame_ready always high -> 30 frame_valid pulses, frame 0 = 0x9876543210, done once, bad_count=0.
REQ-036 Digits 0xA..0xF injected at slots 3 and 7 of frame 5 -> those slots read 0, bad_count=2 at done.
REQ-037 frame_ready held low 20 cycles in ISSUE -> bcd_digits/frame_idx stable, in_ready=0, no digit lost.
REQ-038 abort during frame 12 slot 4 -> IDLE next cycle, no done; new start gives frame_idx=0, bad_count=0.
REQ-039 reset asserted mid-ISSUE -> all outputs at reset values next cycle; start during busy has no effect.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, default sizing and FSM state type for the BCD frame sequencer.
package bcd_pkg;

  // Largest legal BCD digit value.
  localparam int unsigned BCD_MAX = 9;

  // Default frame geometry: 10 digits per frame, 30 frames per run.
  localparam int unsigned DEF_DIGITS_PER_FRAME = 10;
  localparam int unsigned DEF_NUM_FRAMES       = 30;

  // Fixed output widths.
  localparam int unsigned FRAME_IDX_W = 5;
  localparam int unsigned BAD_CNT_W   = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StIssue = 2'd2,
    StDone  = 2'd3
  } bcd_state_e;

  // True when the nibble is a legal BCD digit.
  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Sanitizes one incoming nibble: illegal BCD values are replaced by 0 and flagged.
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] clean_digit,
  output logic       invalid
);

  // Pure combinational check; no state.
  always_comb begin
    invalid     = !is_bcd(digit);
    clean_digit = invalid ? 4'd0 : digit;
  end

endmodule

// File: rtl/bcd_frame_sequencer.sv
// Collects a stream of BCD digits into fixed-size frames and hands each frame to the
// downstream BCD datapath with a valid/ready handshake, for a fixed number of frames per run.
module bcd_frame_sequencer
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS_PER_FRAME = DEF_DIGITS_PER_FRAME,
  parameter int unsigned NUM_FRAMES       = DEF_NUM_FRAMES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          in_valid,
  input  logic [3:0]                    in_digit,
  output logic                          in_ready,
  output logic [4*DIGITS_PER_FRAME-1:0] bcd_digits,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [FRAME_IDX_W-1:0]        frame_idx,
  output logic [BAD_CNT_W-1:0]          bad_count,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned IdxW = (DIGITS_PER_FRAME > 1) ? $clog2(DIGITS_PER_FRAME) : 1;
  localparam int unsigned FrameW = 4 * DIGITS_PER_FRAME;
  localparam logic [IdxW-1:0]        LastSlot  = IdxW'(DIGITS_PER_FRAME - 1);
  localparam logic [FRAME_IDX_W-1:0] LastFrame = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [BAD_CNT_W-1:0]   BadMax    = {BAD_CNT_W{1'b1}};

  bcd_state_e             state_q, state_d;
  logic [IdxW-1:0]        digit_idx_q, digit_idx_d;
  logic [FRAME_IDX_W-1:0] frame_idx_q, frame_idx_d;
  logic [BAD_CNT_W-1:0]   bad_count_q, bad_count_d;
  logic [FrameW-1:0]      bcd_digits_q, bcd_digits_d;

  logic [3:0] clean_digit;
  logic       digit_invalid;

  bcd_digit_check u_digit_check (
    .digit       (in_digit),
    .clean_digit (clean_digit),
    .invalid     (digit_invalid)
  );

  // Next-state logic for the run FSM and the frame assembly registers.
  always_comb begin
    state_d      = state_q;
    digit_idx_d  = digit_idx_q;
    frame_idx_d  = frame_idx_q;
    bad_count_d  = bad_count_q;
    bcd_digits_d = bcd_digits_q;

    unique case (state_q)
      StIdle: begin
        // Results of the previous run stay visible until a new run begins.
        if (start && !abort) begin
          state_d      = StFill;
          digit_idx_d  = '0;
          frame_idx_d  = '0;
          bad_count_d  = '0;
          bcd_digits_d = '0;
        end
      end
      StFill: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < DIGITS_PER_FRAME; k++) begin
            if (digit_idx_q == IdxW'(k)) begin
              bcd_digits_d[4*k +: 4] = clean_digit;
            end
          end
          if (digit_invalid && (bad_count_q != BadMax)) begin
            bad_count_d = bad_count_q + 1'b1;
          end
          if (digit_idx_q == LastSlot) begin
            state_d     = StIssue;
            digit_idx_d = '0;
          end else begin
            digit_idx_d = digit_idx_q + 1'b1;
          end
        end
      end
      StIssue: begin
        if (frame_ready) begin
          if (frame_idx_q == LastFrame) begin
            state_d = StDone;
          end else begin
            state_d     = StFill;
            frame_idx_d = frame_idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort beats any handshake in the same cycle; the partial frame is dropped.
    if (abort) begin
      state_d      = StIdle;
      digit_idx_d  = '0;
      frame_idx_d  = frame_idx_q;
      bad_count_d  = bad_count_q;
      bcd_digits_d = bcd_digits_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      digit_idx_q  <= '0;
      frame_idx_q  <= '0;
      bad_count_q  <= '0;
      bcd_digits_q <= '0;
    end else begin
      state_q      <= state_d;
      digit_idx_q  <= digit_idx_d;
      frame_idx_q  <= frame_idx_d;
      bad_count_q  <= bad_count_d;
      bcd_digits_q <= bcd_digits_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    in_ready    = (state_q == StFill);
    frame_valid = (state_q == StIssue);
    busy        = (state_q == StFill) || (state_q == StIssue);
    done        = (state_q == StDone);
    bcd_digits  = bcd_digits_q;
    frame_idx   = frame_idx_q;
    bad_count   = bad_count_q;
  end

endmodule

// File: tb/tb_bcd_frame_sequencer.sv
// Directed bench for bcd_frame_sequencer with a frame scoreboard.
module tb_bcd_frame_sequencer;

  localparam int D  = 10;
  localparam int NF = 30;

  typedef struct {
    logic [4:0]     idx;
    logic [4*D-1:0] frame;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic           abort;
  logic           in_valid;
  logic [3:0]     in_digit;
  logic           in_ready;
  logic [4*D-1:0] bcd_digits;
  logic           frame_valid;
  logic           frame_ready;
  logic [4:0]     frame_idx;
  logic [8:0]     bad_count;
  logic           busy;
  logic           done;

  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;
  int done_count  = 0;

  exp_t           exp_q[$];
  logic [4*D-1:0] seen[32];

  // Bench model of the frame being assembled.
  logic [4*D-1:0] mdl_frame;
  int             mdl_slot;
  int             mdl_fidx;
  int             mdl_bad;

  bcd_frame_sequencer #(
    .DIGITS_PER_FRAME (D),
    .NUM_FRAMES       (NF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_digit    (in_digit),
    .in_ready    (in_ready),
    .bcd_digits  (bcd_digits),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_idx   (frame_idx),
    .bad_count   (bad_count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every frame handshake.
  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      exp_t e;
      hs_count++;
      seen[frame_idx] = bcd_digits;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_underflow observed=frame_%0d expected=no_frame", frame_idx);
      end else begin
        e = exp_q.pop_front();
        check("sb_frame", 64'(bcd_digits), 64'(e.frame));
        check("sb_idx", 64'(frame_idx), 64'(e.idx));
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_count++;
  end

  task automatic model_clear();
    mdl_frame = '0;
    mdl_slot  = 0;
    mdl_fidx  = 0;
    mdl_bad   = 0;
  endtask

  // Offer one digit until accepted; updates the model on acceptance.
  task automatic send_digit(input logic [3:0] d);
    bit ok = 1'b0;
    exp_t e;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      in_digit = d;
      in_valid = 1'b1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      vectors++;
      miscompares++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end else begin
      mdl_frame[4*mdl_slot +: 4] = (d > 4'd9) ? 4'd0 : d;
      if (d > 4'd9 && mdl_bad < 511) mdl_bad++;
      mdl_slot++;
      if (mdl_slot == D) begin
        e.idx   = 5'(mdl_fidx);
        e.frame = mdl_frame;
        exp_q.push_back(e);
        mdl_slot = 0;
        mdl_fidx++;
      end
    end
  endtask

  // One frame of digits s%10; frame bad_f gets illegal digits at slots 3 and 7,
  // frame stall_f is held in ISSUE for 20 cycles with a stray digit offered.
  task automatic send_frame(input int f, input int bad_f, input int stall_f, input bit chk_lat);
    logic [3:0] d;
    for (int s = 0; s < D; s++) begin
      d = 4'(s % 10);
      if (f == bad_f && s == 3) d = 4'hA;
      if (f == bad_f && s == 7) d = 4'hF;
      send_digit(d);
      if (f == stall_f && s == 0) frame_ready = 1'b0;
    end
    if (chk_lat) begin
      @(negedge clk);
      check("latency_fv", 64'(frame_valid), 64'd1);
    end
    if (f == stall_f) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_digit = 4'd7;
        check("stall_fv", 64'(frame_valid), 64'd1);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        if (exp_q.size() > 0) begin
          check("stall_digits", 64'(bcd_digits), 64'(exp_q[0].frame));
          check("stall_idx", 64'(frame_idx), 64'(exp_q[0].idx));
        end
      end
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      frame_ready = 1'b1;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_in_ready", 64'(in_ready), 64'd1);
    check("start_fidx", 64'(frame_idx), 64'd0);
    check("start_bad", 64'(bad_count), 64'd0);
    check("start_digits", 64'(bcd_digits), 64'd0);
    model_clear();
  endtask

  task automatic wait_done(input int exp_bad);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    check("done_bad", 64'(bad_count), 64'(exp_bad));
    check("done_fidx", 64'(frame_idx), 64'(NF - 1));
    @(negedge clk);
    check("done_pulse_len", 64'(done), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_fv"}, 64'(frame_valid), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_fidx"}, 64'(frame_idx), 64'd0);
    check({tag, "_bad"}, 64'(bad_count), 64'd0);
    check({tag, "_digits"}, 64'(bcd_digits), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    in_valid    = 1'b0;
    in_digit    = 4'd0;
    frame_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Run 1: clean stream, downstream always ready.
    do_start();
    for (int f = 0; f < NF; f++) send_frame(f, -1, -1, 1'b1);
    wait_done(0);
    check("run1_frame0", 64'(seen[0]), 64'h98_7654_3210);
    check("run1_frames", 64'(hs_count), 64'd30);
    check("run1_done_cnt", 64'(done_count), 64'd1);

    // Run 2: illegal digits in frame 5, backpressure on frame 3.
    do_start();
    for (int f = 0; f < NF; f++) send_frame(f, 5, 3, 1'b0);
    wait_done(2);
    check("run2_frame5", 64'(seen[5]), 64'h98_0654_0210);
    check("run2_frames", 64'(hs_count), 64'd60);
    check("run2_done_cnt", 64'(done_count), 64'd2);

    // Run 3: abort at frame 12 slot 4 with a digit offered in the same cycle.
    do_start();
    for (int f = 0; f < 12; f++) send_frame(f, 0, -1, 1'b0);
    for (int s = 0; s < 4; s++) send_digit(4'(s));
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_digit = 4'd4;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_fv", 64'(frame_valid), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_bad_hold", 64'(bad_count), 64'(mdl_bad));
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_count), 64'd2);
    check("abort_frames", 64'(hs_count), 64'd72);
    exp_q.delete();

    // Run 4: fresh start, start ignored while busy, reset mid-ISSUE.
    frame_ready = 1'b0;
    do_start();
    send_frame(0, -1, -1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_fv", 64'(frame_valid), 64'd1);
    check("busy_start_busy", 64'(busy), 64'd1);
    check("busy_start_fidx", 64'(frame_idx), 64'd0);
    check("busy_start_digits", 64'(bcd_digits), 64'h98_7654_3210);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset       = 1'b0;
    frame_ready = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("final_idle_busy", 64'(busy), 64'd0);
    check("final_frames", 64'(hs_count), 64'd72);
    check("final_done_cnt", 64'(done_count), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
